// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the matrix-keypad emulator.
//   kp_state_t - press sequencer states
//   KEY_ROWS / KEY_COLS - keypad matrix geometry
//   COL_IDLE   - active-low column value when no key is closed
//   LFSR_TAPS  - feedback mask for the 16-bit chatter LFSR (taps 16,14,13,11)
//   lfsr_next  - one Fibonacci step, feedback shifted in at bit 0
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BOUNCE_IN  = 2'd1,
        HOLD       = 2'd2,
        BOUNCE_OUT = 2'd3
    } kp_state_t;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    localparam logic [KEY_COLS-1:0] COL_IDLE = 4'hF;

    // Bits 15,13,12,10 correspond to polynomial taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/chatter_lfsr.sv
// chatter_lfsr: 16-bit Fibonacci LFSR used as the contact-chatter source.
//   clk   - system clock
//   RST   - synchronous active-high reset, loads SEED
//   en    - advance one step on this edge
//   state - current LFSR contents (never zero for a nonzero SEED)
module chatter_lfsr
    import keypad_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 active-low matrix keypad.
// Takes "press key K for T" commands and drives the column returns as a
// real key would, including pseudo-random contact bounce on make and break.
//
// Ports:
//   clk        - system clock
//   RST        - synchronous active-high reset
//   cmd_valid  - press command present
//   cmd_ready  - command accepted on this edge if cmd_valid (IDLE only)
//   cmd_key    - key index, row = [3:2], column = [1:0]
//   cmd_hold   - stable-closed time in HOLD_TICK units (0 acts as 1)
//   row        - row strobes from the scanner, active-low
//   col        - column returns, active-low, combinational from row
//   busy       - press sequence in progress
//   done       - one-cycle pulse in the first IDLE cycle after a press
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | contact open, waiting for a command
// BOUNCE_IN  | make chatter, BOUNCE_LEN cycles, contact closed at the end
// HOLD       | contact solidly closed for hold*HOLD_TICK cycles
// BOUNCE_OUT | break chatter, BOUNCE_LEN cycles, contact opened at the end
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_LEN  = 500000,
    parameter int unsigned CHATTER_DIV = 5000,
    parameter int unsigned HOLD_TICK   = 50000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_key,
    input  logic [7:0]          cmd_hold,
    input  logic [KEY_ROWS-1:0] row,
    output logic [KEY_COLS-1:0] col,
    output logic                busy,
    output logic                done
);

    localparam int unsigned HOLD_MAX = HOLD_TICK * 255;
    localparam int unsigned TMR_MAX  = (HOLD_MAX > BOUNCE_LEN) ? HOLD_MAX : BOUNCE_LEN;
    localparam int          TMR_W    = $clog2(TMR_MAX + 1);
    localparam int          DIV_W    = (CHATTER_DIV > 1) ? $clog2(CHATTER_DIV) : 1;

    localparam logic [TMR_W-1:0] BOUNCE_LOAD = (BOUNCE_LEN > 0) ? TMR_W'(BOUNCE_LEN - 1) : '0;
    localparam logic [TMR_W-1:0] TICK        = TMR_W'(HOLD_TICK);
    localparam logic [DIV_W-1:0] DIV_LOAD    = DIV_W'(CHATTER_DIV - 1);

    kp_state_t        state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic             contact, contact_nxt;
    logic [3:0]       key_r, key_nxt;
    logic [7:0]       hold_r, hold_nxt;
    logic             done_nxt;
    logic             lfsr_en;
    logic [15:0]      lfsr;

    logic [7:0]       hold_in_eff;
    logic [7:0]       mul_hold;
    logic [TMR_W-1:0] hold_load;

    chatter_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .RST   (RST),
        .en    (lfsr_en),
        .state (lfsr)
    );

    // Only bit 0 drives the contact; the rest exists to keep the sequence long.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[15:1];

    // One multiplier serves both load points: the incoming command when the
    // bounce-free path jumps straight from IDLE to HOLD, the latched value otherwise.
    assign hold_in_eff = (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
    assign mul_hold    = (state == IDLE) ? hold_in_eff : hold_r;
    assign hold_load   = TMR_W'(mul_hold) * TICK - TMR_W'(1);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            timer   <= '0;
            div_cnt <= '0;
            contact <= 1'b0;
            key_r   <= 4'd0;
            hold_r  <= 8'd0;
            done    <= 1'b0;
        end else begin
            timer   <= timer_nxt;
            div_cnt <= div_nxt;
            contact <= contact_nxt;
            key_r   <= key_nxt;
            hold_r  <= hold_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        div_nxt     = div_cnt;
        contact_nxt = contact;
        key_nxt     = key_r;
        hold_nxt    = hold_r;
        done_nxt    = 1'b0;
        lfsr_en     = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    key_nxt  = cmd_key;
                    hold_nxt = hold_in_eff;
                    div_nxt  = DIV_LOAD;
                    if (BOUNCE_LEN == 0) begin
                        state_nxt   = HOLD;
                        timer_nxt   = hold_load;
                        contact_nxt = 1'b1;
                    end else begin
                        state_nxt = BOUNCE_IN;
                        timer_nxt = BOUNCE_LOAD;
                    end
                end
            end

            BOUNCE_IN, BOUNCE_OUT: begin
                // Contact takes the LFSR bit present at the advance edge.
                if (div_cnt == '0) begin
                    lfsr_en     = 1'b1;
                    contact_nxt = lfsr[0];
                    div_nxt     = DIV_LOAD;
                end else begin
                    div_nxt = div_cnt - 1'b1;
                end

                // Window end overrides whatever the chatter chose on that edge.
                if (timer == '0) begin
                    if (state == BOUNCE_IN) begin
                        state_nxt   = HOLD;
                        timer_nxt   = hold_load;
                        contact_nxt = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        contact_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end

            HOLD: begin
                if (timer == '0) begin
                    if (BOUNCE_LEN == 0) begin
                        state_nxt   = IDLE;
                        contact_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else begin
                        state_nxt = BOUNCE_OUT;
                        timer_nxt = BOUNCE_LOAD;
                        div_nxt   = DIV_LOAD;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
        endcase
    end

    // Live row input keeps this path free of latency for the scanner.
    always_comb begin
        col = COL_IDLE;
        if (contact && !row[key_r[3:2]]) begin
            col[key_r[1:0]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: unit 0 with bounce (BOUNCE_LEN=8), unit 1
// bounce-free (BOUNCE_LEN=0); both CHATTER_DIV=2, HOLD_TICK=4.
module tb_keypad_emulator;

    localparam int          DIV  = 2;
    localparam int          TICK = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            RST;
    logic [1:0]      cmd_valid_v, ready_v, busy_v, done_v;
    logic [1:0][3:0] key_v, row_v, col_v;
    logic [1:0][7:0] hold_v;

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_LEN(8), .CHATTER_DIV(DIV), .HOLD_TICK(TICK), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .RST(RST), .cmd_valid(cmd_valid_v[0]), .cmd_ready(ready_v[0]),
        .cmd_key(key_v[0]), .cmd_hold(hold_v[0]), .row(row_v[0]), .col(col_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    keypad_emulator #(.BOUNCE_LEN(0), .CHATTER_DIV(DIV), .HOLD_TICK(TICK), .LFSR_SEED(SEED)) dut_nb (
        .clk(clk), .RST(RST), .cmd_valid(cmd_valid_v[1]), .cmd_ready(ready_v[1]),
        .cmd_key(key_v[1]), .cmd_hold(hold_v[1]), .row(row_v[1]), .col(col_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    typedef struct {
        int unit;
        int len;
    } sb_t;
    sb_t sb_q[$];

    logic [15:0] m_lfsr[2];
    bit          exp_ct[0:127];
    logic [3:0]  col_log[0:127];

    function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic logic [3:0] exp_col(input logic [3:0] k, input bit ct, input logic [3:0] r);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) begin
            v[c] = !(ct && (c == int'(k[1:0])) && (r[k[3:2]] == 1'b0));
        end
        return v;
    endfunction

    // Expected contact level during each cycle c after the accept edge.
    task automatic gen_contact(input int u, input int bl, input int hc);
        bit cur;
        int d;
        d   = 2 * bl + hc;
        cur = (bl == 0);
        for (int c = 1; c <= d + 1; c++) begin
            exp_ct[c] = cur;
            if (c <= bl || (c > bl + hc && c <= d)) begin
                int j;
                j = (c <= bl) ? c : c - bl - hc;
                if (j % DIV == 0) begin
                    cur       = m_lfsr[u][0];
                    m_lfsr[u] = lfsr_ref(m_lfsr[u]);
                end
                if (j == bl) cur = (c <= bl);
            end else if (bl == 0 && c == hc) begin
                cur = 1'b0;
            end
        end
    endtask

    task automatic press(input int u, input logic [3:0] key, input logic [7:0] hold,
                         input logic [3:0] rowa, input logic [3:0] rowb,
                         input bit pre, input bit chain, input logic [3:0] nkey,
                         input int abort_c);
        int h, bl, d;
        sb_t e;
        h  = (hold == 8'd0) ? 1 : int'(hold);
        bl = (u == 0) ? 8 : 0;
        d  = 2 * bl + h * TICK;
        gen_contact(u, bl, h * TICK);
        if (!pre) begin
            @(negedge clk);
            cmd_valid_v[u] = 1'b1;
            key_v[u]       = key;
            hold_v[u]      = hold;
        end
        if (abort_c == 0) begin
            e.unit = u;
            e.len  = d;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (chain) key_v[u] = nkey;
        else cmd_valid_v[u] = 1'b0;
        for (int c = 1; c <= d + 1; c++) begin
            if (c == abort_c) begin
                RST = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_col", col_v[u], 4'hF);
                chk("abort_ready", ready_v[u], 1);
                chk("abort_busy", busy_v[u], 0);
                m_lfsr[0] = SEED;
                m_lfsr[1] = SEED;
                @(negedge clk);
                RST = 1'b0;
                return;
            end
            row_v[u] = (c % 3 == 0) ? rowb : rowa;
            #1;
            col_log[c] = col_v[u];
            chk("col", col_v[u], exp_col(key, exp_ct[c], row_v[u]));
            chk("ready", ready_v[u], (c == d + 1) ? 1 : 0);
            chk("busy", busy_v[u], (c <= d) ? 1 : 0);
            if (c <= d) @(negedge clk);
        end
    endtask

    // Scoreboard consumer: measures each busy run and pairs it with done.
    int cnt[2], last_len[2];
    bit prev_busy[2], prev_done[2];

    always @(negedge clk) begin
        #2;
        for (int u = 0; u < 2; u++) begin
            if (RST) begin
                cnt[u]       = 0;
                prev_busy[u] = 0;
                prev_done[u] = 0;
            end else begin
                if (!busy_v[u] && prev_busy[u]) begin
                    last_len[u] = cnt[u];
                    cnt[u]      = 0;
                end
                if (busy_v[u]) cnt[u]++;
                if (done_v[u]) begin
                    if (prev_done[u]) chk("done_width", 2, 1);
                    if (sb_q.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        chk("sb_unit", u, e.unit);
                        chk("busy_len", last_len[u], e.len);
                        chk("done_after_busy", prev_busy[u], 1);
                    end
                end
                prev_busy[u] = busy_v[u];
                prev_done[u] = done_v[u];
            end
        end
    end

    int tog;

    initial begin
        RST         = 1'b1;
        cmd_valid_v = '0;
        key_v       = '0;
        hold_v      = '0;
        row_v       = {4'hF, 4'hF};
        m_lfsr[0]   = SEED;
        m_lfsr[1]   = SEED;

        // Reset held with rows toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            row_v = (i % 2 == 0) ? {4'h0, 4'h0} : {4'hA, 4'h5};
            #1;
            for (int u = 0; u < 2; u++) begin
                chk("rst_col", col_v[u], 4'hF);
                chk("rst_ready", ready_v[u], 1);
                chk("rst_busy", busy_v[u], 0);
                chk("rst_done", done_v[u], 0);
            end
        end
        @(negedge clk);
        RST   = 1'b0;
        row_v = {4'hF, 4'hF};

        // Bounce-free key 5, hold 3.
        press(1, 4'd5, 8'd3, 4'b1101, 4'b1110, 0, 0, 4'd0, 0);

        // Bounced key 10, hold 2.
        press(0, 4'd10, 8'd2, 4'b1011, 4'b1011, 0, 0, 4'd0, 0);
        tog = 0;
        for (int c = 2; c <= 8; c++) if (col_log[c] !== col_log[c-1]) tog++;
        chk("chatter_in", (tog > 0) ? 1 : 0, 1);
        tog = 0;
        for (int c = 18; c <= 24; c++) if (col_log[c] !== col_log[c-1]) tog++;
        chk("chatter_out", (tog > 0) ? 1 : 0, 1);

        // Key 3 requested throughout a key-7 press.
        press(1, 4'd7, 8'd1, 4'b1110, 4'b1101, 0, 1, 4'd3, 0);
        press(1, 4'd3, 8'd1, 4'b1110, 4'b1110, 1, 0, 4'd0, 0);

        // Reset in the middle of HOLD, then a fresh press.
        press(0, 4'd10, 8'd2, 4'b1011, 4'b1011, 0, 0, 4'd0, 12);
        press(0, 4'd10, 8'd2, 4'b1011, 4'b1011, 0, 0, 4'd0, 0);

        // hold 0 acts as hold 1.
        press(1, 4'd12, 8'd0, 4'b0111, 4'b1111, 0, 0, 4'd0, 0);

        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
